dcache_wt: RTL



---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_array.sv | 56 +++++
 rtl/dcache_wt.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, FSM encoding and helpers for the write-through data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned INDEX_W = 6;
    localparam int unsigned CNT_W   = 16;

    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;
    localparam int unsigned WADDR_W = ADDR_W - 2;
    localparam int unsigned LINES   = 2 ** INDEX_W;

    // Word address the memory stage never services.
    localparam logic [WADDR_W-1:0] RSVD_WADDR = '0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_LOW  = 3'd1,
        S_RD_HIGH = 3'd2,
        S_WR_LOW  = 3'd3,
        S_WR_HIGH = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/data/valid storage for a direct-mapped one-word-per-line cache.
// Ports:
//   iCLK, iRST_n          clock, async active-low reset (clears valid bits)
//   clr                   clear all valid bits on the next edge (wins over a write)
//   rd_index              combinational read index
//   rd_valid/rd_tag/rd_data  read port outputs
//   we                    write data_ram[wr_index] with wr_data
//   fill                  with we: also write tag and set valid
//   wr_index/wr_tag/wr_data  write port
module dcache_array
    import dcache_pkg::*;
(
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic               clr,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               we,
    input  logic               fill,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [DATA_W-1:0] data_ram [LINES];

    // Valid bits: the only reset state the array needs.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (we && fill) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data payload; contents are meaningless while the line is invalid.
    always_ff @(posedge iCLK) begin
        if (we) begin
            data_ram[wr_index] <= wr_data;
            if (fill) begin
                tag_ram[wr_index] <= wr_tag;
            end
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_ram[rd_index];
    assign rd_data  = data_ram[rd_index];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read hits complete in the request cycle; misses fetch one word and stores
// write one word through the level request / data_ready memory handshake.
// Ports:
//   iCLK, iRST_n                 clock, async active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   core request (held while cpu_stall)
//   cpu_rdata, cpu_stall         load data and hold request (combinational)
//   cache_inv                    invalidate all lines
//   mem_addr/mem_MemRead/mem_MemWrite/mem_data_in   registered memory request
//   mem_data_out, data_ready     memory response; data_ready high = idle
//   hit_cnt, miss_cnt            saturating load hit/miss counters
module dcache_wt
    import dcache_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              cache_inv,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              data_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t              state, state_d;
    logic                rd_d, wr_d, pend_d, inv_pend;
    logic [ADDR_W-1:0]   maddr_d;
    logic [DATA_W-1:0]   mdin_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]    hit_d, miss_d;

    logic [WADDR_W-1:0]  waddr;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                waddr0, hit, inv_now;
    logic                arr_we, arr_fill, arr_clr;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data, arr_wdata;

    // Byte offset is never used by a word-only cache.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign waddr   = cpu_addr[ADDR_W-1:2];
    assign index   = cpu_addr[INDEX_W+1:2];
    assign tag     = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign waddr0  = (waddr == RSVD_WADDR);
    assign hit     = rd_valid && (rd_tag == tag);
    // Invalidate requested now or deferred from a busy period.
    assign inv_now = (state == S_IDLE) && (cache_inv || inv_pend);

    dcache_array u_array (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .clr      (arr_clr),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (arr_we),
        .fill     (arr_fill),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_data  (arr_wdata)
    );

    // Fills take memory data; store hits take the core's data.
    assign arr_wdata = arr_fill ? mem_data_out : cpu_wdata;

    // Stall: IDLE completes reserved-word accesses and load hits at once.
    always_comb begin
        cpu_stall = 1'b1;
        case (state)
            S_IDLE:  cpu_stall = cpu_req && (inv_now || !(waddr0 || (!cpu_we && hit)));
            S_DONE:  cpu_stall = 1'b0;
            default: cpu_stall = 1'b1;
        endcase
    end

    // Load data: registered fill result in DONE, array read on an IDLE hit.
    always_comb begin
        cpu_rdata = '0;
        if (state == S_DONE) begin
            cpu_rdata = rdata_q;
        end else if ((state == S_IDLE) && hit && !waddr0) begin
            cpu_rdata = rd_data;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state;
        rd_d     = mem_MemRead;
        wr_d     = mem_MemWrite;
        maddr_d  = mem_addr;
        mdin_d   = mem_data_in;
        rdata_d  = rdata_q;
        hit_d    = hit_cnt;
        miss_d   = miss_cnt;
        pend_d   = (state == S_IDLE) ? 1'b0 : (inv_pend || cache_inv);
        arr_we   = 1'b0;
        arr_fill = 1'b0;
        arr_clr  = 1'b0;

        case (state)
            S_IDLE: begin
                if (inv_now) begin
                    arr_clr = 1'b1;
                end else if (cpu_req && !waddr0) begin
                    if (!cpu_we && hit) begin
                        hit_d = sat_inc(hit_cnt);
                    end else if (data_ready) begin
                        maddr_d = {2'b00, waddr};
                        if (cpu_we) begin
                            wr_d    = 1'b1;
                            mdin_d  = cpu_wdata;
                            state_d = S_WR_LOW;
                        end else begin
                            rd_d    = 1'b1;
                            miss_d  = sat_inc(miss_cnt);
                            state_d = S_RD_LOW;
                        end
                    end
                end
            end
            S_RD_LOW: begin
                if (!data_ready) state_d = S_RD_HIGH;
            end
            S_RD_HIGH: begin
                if (data_ready) begin
                    rd_d     = 1'b0;
                    arr_we   = 1'b1;
                    arr_fill = 1'b1;
                    rdata_d  = mem_data_out;
                    state_d  = S_DONE;
                end
            end
            S_WR_LOW: begin
                if (!data_ready) state_d = S_WR_HIGH;
            end
            S_WR_HIGH: begin
                if (data_ready) begin
                    wr_d    = 1'b0;
                    arr_we  = hit;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= S_IDLE;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            rdata_q      <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            inv_pend     <= 1'b0;
        end else begin
            state        <= state_d;
            mem_MemRead  <= rd_d;
            mem_MemWrite <= wr_d;
            mem_addr     <= maddr_d;
            mem_data_in  <= mdin_d;
            rdata_q      <= rdata_d;
            hit_cnt      <= hit_d;
            miss_cnt     <= miss_d;
            inv_pend     <= pend_d;
        end
    end

endmodule
